// File: rtl/frame_update_scheduler_pkg.sv
// Shared stage indices, FSM encodings and 640x480 trigger defaults for the frame update scheduler.
package frame_update_scheduler_pkg;

   localparam int NUM_STAGES = 4;

   localparam logic [1:0] STG_PLAYER = 2'd0;
   localparam logic [1:0] STG_PROJ   = 2'd1;
   localparam logic [1:0] STG_FLEET  = 2'd2;
   localparam logic [1:0] STG_COLL   = 2'd3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // First blanking line, column 0, of a 640x480 raster.
   localparam logic [9:0] H_TRIGGER_DEF = 10'd0;
   localparam logic [9:0] V_TRIGGER_DEF = 10'd480;

   function automatic logic [NUM_STAGES-1:0] stage_onehot(input logic [1:0] idx);
      logic [NUM_STAGES-1:0] one;
      one = {{(NUM_STAGES-1){1'b0}}, 1'b1};
      return one << idx;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame tick: rising edge of the raster trigger match, divided by FRAME_DIV; registered, 1 cycle after the match edge.
module frame_tick_gen
   import frame_update_scheduler_pkg::*;
#(
   parameter logic [9:0]  H_TRIGGER = H_TRIGGER_DEF,
   parameter logic [9:0]  V_TRIGGER = V_TRIGGER_DEF,
   parameter int unsigned FRAME_DIV = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [9:0] hCount,
   input  logic [9:0] vCount,
   input  logic       game_playing,
   output logic       frame_tick
);

   localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

   logic       match;
   logic       match_q;
   logic       raw_tick;
   logic [7:0] div_q, div_d;
   logic       tick_q, tick_d;

   // Counters hold each value for many clocks, so only the first matching cycle counts.
   assign match    = (hCount == H_TRIGGER) && (vCount == V_TRIGGER);
   assign raw_tick = match & ~match_q;

   always_comb begin
      div_d  = div_q;
      tick_d = 1'b0;
      if (raw_tick && game_playing) begin
         if (div_q == DIV_LAST) begin
            div_d  = 8'd0;
            tick_d = 1'b1;
         end else begin
            div_d = div_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         match_q <= 1'b0;
         div_q   <= 8'd0;
         tick_q  <= 1'b0;
      end else begin
         match_q <= match;
         div_q   <= div_d;
         tick_q  <= tick_d;
      end
   end

   assign frame_tick = tick_q;

endmodule

// File: rtl/frame_update_scheduler.sv
// Per-frame sequencer issuing go pulses to player, projectile, fleet and collision stages in order.
// First go 2 cycles after the trigger match edge; each stage waits for its done or TIMEOUT_CYCLES.
module frame_update_scheduler
   import frame_update_scheduler_pkg::*;
#(
   parameter logic [9:0]  H_TRIGGER      = H_TRIGGER_DEF,
   parameter logic [9:0]  V_TRIGGER      = V_TRIGGER_DEF,
   parameter int unsigned FRAME_DIV      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [9:0]            hCount,
   input  logic [9:0]            vCount,
   input  logic                  game_playing,
   input  logic [NUM_STAGES-1:0] stage_done,
   input  logic                  clr_err,
   output logic [NUM_STAGES-1:0] stage_go,
   output logic                  frame_tick,
   output logic                  busy,
   output logic                  overrun,
   output logic                  timeout_err,
   output logic [1:0]            err_stage,
   output logic [15:0]           frame_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [TW-1:0] TO_ONE  = TW'(1);

   logic [1:0]    state_q, state_d;
   logic [1:0]    idx_q, idx_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          overrun_q, overrun_d;
   logic          timeout_q, timeout_d;
   logic [1:0]    err_stage_q, err_stage_d;
   logic [15:0]   fc_q, fc_d;
   logic          stage_fin;
   logic          timed_out;

   frame_tick_gen #(
      .H_TRIGGER (H_TRIGGER),
      .V_TRIGGER (V_TRIGGER),
      .FRAME_DIV (FRAME_DIV)
   ) u_tick (
      .clk          (clk),
      .reset_n      (reset_n),
      .hCount       (hCount),
      .vCount       (vCount),
      .game_playing (game_playing),
      .frame_tick   (frame_tick)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      to_cnt_d    = to_cnt_q;
      fc_d        = fc_q;
      overrun_d   = overrun_q;
      timeout_d   = timeout_q;
      err_stage_d = err_stage_q;
      stage_fin   = 1'b0;
      timed_out   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (frame_tick && game_playing) begin
               state_d = ST_ISSUE;
               idx_d   = STG_PLAYER;
            end
         end
         ST_ISSUE: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            // A real done on the last counted cycle wins over the timeout.
            if (stage_done[idx_q]) begin
               stage_fin = 1'b1;
            end else if (to_cnt_q == TO_LAST) begin
               stage_fin = 1'b1;
               timed_out = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_ONE;
            end
            if (stage_fin) begin
               if (idx_q == STG_COLL) begin
                  state_d = ST_DONE;
               end else if (!game_playing) begin
                  state_d = ST_IDLE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_ISSUE;
               end
            end
         end
         default: begin
            fc_d    = fc_q + 16'd1;
            state_d = ST_IDLE;
         end
      endcase

      // Clear first so that a coincident set takes priority.
      if (clr_err) begin
         overrun_d   = 1'b0;
         timeout_d   = 1'b0;
         err_stage_d = 2'd0;
      end
      if (frame_tick && (state_q != ST_IDLE)) begin
         overrun_d = 1'b1;
      end
      if (timed_out) begin
         timeout_d = 1'b1;
         if (!timeout_q || clr_err) begin
            err_stage_d = idx_q;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         idx_q       <= STG_PLAYER;
         to_cnt_q    <= '0;
         overrun_q   <= 1'b0;
         timeout_q   <= 1'b0;
         err_stage_q <= 2'd0;
         fc_q        <= 16'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         to_cnt_q    <= to_cnt_d;
         overrun_q   <= overrun_d;
         timeout_q   <= timeout_d;
         err_stage_q <= err_stage_d;
         fc_q        <= fc_d;
      end
   end

   assign stage_go    = (state_q == ST_ISSUE) ? stage_onehot(idx_q) : '0;
   assign busy        = (state_q != ST_IDLE);
   assign overrun     = overrun_q;
   assign timeout_err = timeout_q;
   assign err_stage   = err_stage_q;
   assign frame_count = fc_q;

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Directed bench for frame_update_scheduler: trigger-table vectors plus hand-written sequence corner cases.
module tb_frame_update_scheduler;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [9:0]  hCount;
   logic [9:0]  vCount;
   logic        game_playing;
   logic        clr_err;
   logic [3:0]  stage_done, stage_done3;
   logic [3:0]  stage_go, stage_go3;
   logic        frame_tick, frame_tick3;
   logic        busy, busy3;
   logic        overrun, overrun3;
   logic        timeout_err, timeout_err3;
   logic [1:0]  err_stage, err_stage3;
   logic [15:0] frame_count, frame_count3;

   int n_chk  = 0;
   int n_fail = 0;

   int go_pulses = 0;
   int go0_cnt   = 0;
   int busy_cnt  = 0;
   int tick_cnt  = 0;
   int tick3_cnt = 0;

   int dly[4];
   int pend[4];
   int pend3[4];

   typedef struct {
      logic [9:0] h;
      logic [9:0] v;
      logic       gp;
      int         hold;
      int         exp_ticks;
      int         exp_fc;
      int         exp_ticks3;
      int         exp_fc3;
   } vec_t;

   vec_t vecs[8];

   always #5 clk = ~clk;

   frame_update_scheduler #(
      .FRAME_DIV      (1),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .hCount       (hCount),
      .vCount       (vCount),
      .game_playing (game_playing),
      .stage_done   (stage_done),
      .clr_err      (clr_err),
      .stage_go     (stage_go),
      .frame_tick   (frame_tick),
      .busy         (busy),
      .overrun      (overrun),
      .timeout_err  (timeout_err),
      .err_stage    (err_stage),
      .frame_count  (frame_count)
   );

   frame_update_scheduler #(
      .FRAME_DIV      (3),
      .TIMEOUT_CYCLES (16)
   ) dut3 (
      .clk          (clk),
      .reset_n      (reset_n),
      .hCount       (hCount),
      .vCount       (vCount),
      .game_playing (game_playing),
      .stage_done   (stage_done3),
      .clr_err      (clr_err),
      .stage_go     (stage_go3),
      .frame_tick   (frame_tick3),
      .busy         (busy3),
      .overrun      (overrun3),
      .timeout_err  (timeout_err3),
      .err_stage    (err_stage3),
      .frame_count  (frame_count3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_go(input logic [3:0] mask, input int budget, output int waited);
      waited = -1;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (stage_go == mask) begin
            waited = i + 1;
            break;
         end
      end
      if (waited < 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_go_%b: no go within %0d cycles", mask, budget);
      end
   endtask

   task automatic wait_idle(input int budget);
      int ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         cyc();
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_idle: still busy after %0d cycles", budget);
      end
   endtask

   task automatic do_reset();
      hCount  = 10'd1;
      vCount  = 10'd0;
      reset_n = 1'b0;
      repeat (3) cyc();
      reset_n = 1'b1;
      cyc();
   endtask

   task automatic raw_tick(input int hold);
      hCount = 10'd0;
      vCount = 10'd480;
      repeat (hold) cyc();
      hCount = 10'd1;
   endtask

   // Raises the trigger and checks the first go lands two cycles after the match edge.
   task automatic start_seq(input string name);
      int w;
      hCount = 10'd0;
      vCount = 10'd480;
      wait_go(4'b0001, 10, w);
      chk({name, "_go0_latency"}, w, 2);
      hCount = 10'd1;
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (stage_go != 4'b0000) begin
            go_pulses++;
            chk("go_onehot", $countones(stage_go), 1);
         end
         if (stage_go == 4'b0001) go0_cnt++;
         if (busy) busy_cnt++;
         if (frame_tick) tick_cnt++;
         if (frame_tick3) tick3_cnt++;
      end
   end

   initial begin : responder
      logic [3:0] nd, nd3;
      stage_done  = 4'b0000;
      stage_done3 = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         pend[i]  = 0;
         pend3[i] = 0;
      end
      forever begin
         @(negedge clk);
         nd  = 4'b0000;
         nd3 = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if (stage_go[i]) begin
               pend[i] = dly[i];
            end else if (pend[i] > 0) begin
               pend[i] = pend[i] - 1;
               if (pend[i] == 0) nd[i] = 1'b1;
            end
            if (stage_go3[i]) begin
               pend3[i] = 3;
            end else if (pend3[i] > 0) begin
               pend3[i] = pend3[i] - 1;
               if (pend3[i] == 0) nd3[i] = 1'b1;
            end
         end
         stage_done  = nd;
         stage_done3 = nd3;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int w, tk, tk3, g0, b0;

      vecs[0] = '{10'd0,   10'd480, 1'b1, 24, 1, 1, 0, 0};
      vecs[1] = '{10'd1,   10'd480, 1'b1,  6, 0, 1, 0, 0};
      vecs[2] = '{10'd0,   10'd479, 1'b1,  6, 0, 1, 0, 0};
      vecs[3] = '{10'd0,   10'd480, 1'b0,  6, 0, 1, 0, 0};
      vecs[4] = '{10'd5,   10'd0,   1'b0,  6, 0, 1, 0, 0};
      vecs[5] = '{10'd0,   10'd480, 1'b1, 24, 1, 2, 0, 0};
      vecs[6] = '{10'd639, 10'd480, 1'b1,  6, 0, 2, 0, 0};
      vecs[7] = '{10'd0,   10'd480, 1'b1, 24, 1, 3, 1, 1};

      for (int i = 0; i < 4; i++) dly[i] = 3;
      game_playing = 1'b1;
      clr_err      = 1'b0;
      hCount       = 10'd1;
      vCount       = 10'd0;
      reset_n      = 1'b0;
      repeat (3) cyc();
      chk("rst_stage_go", stage_go, 0);
      chk("rst_frame_tick", frame_tick, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout_err", timeout_err, 0);
      chk("rst_err_stage", err_stage, 0);
      chk("rst_frame_count", frame_count, 0);
      chk("rst3_busy", busy3, 0);
      chk("rst3_frame_count", frame_count3, 0);
      chk("rst3_errors", {overrun3, timeout_err3, err_stage3}, 0);
      reset_n = 1'b1;
      cyc();

      // Nominal sequence, each stage done 3 cycles after its go.
      g0 = go_pulses;
      b0 = busy_cnt;
      start_seq("t1");
      wait_go(4'b0010, 10, w);
      chk("t1_gap_go1", w, 4);
      wait_go(4'b0100, 10, w);
      chk("t1_gap_go2", w, 4);
      wait_go(4'b1000, 10, w);
      chk("t1_gap_go3", w, 4);
      wait_idle(10);
      cyc();
      chk("t1_go_pulses", go_pulses - g0, 4);
      chk("t1_busy_cycles", busy_cnt - b0, 17);
      chk("t1_frame_count", frame_count, 1);
      chk("t1_no_timeout", timeout_err, 0);

      // Trigger-detect and division vectors.
      do_reset();
      for (int r = 0; r < 8; r++) begin
         tk  = tick_cnt;
         tk3 = tick3_cnt;
         hCount       = vecs[r].h;
         vCount       = vecs[r].v;
         game_playing = vecs[r].gp;
         repeat (vecs[r].hold) cyc();
         chk($sformatf("vec%0d_ticks", r), tick_cnt - tk, vecs[r].exp_ticks);
         chk($sformatf("vec%0d_frame_count", r), frame_count, vecs[r].exp_fc);
         chk($sformatf("vec%0d_ticks_div3", r), tick3_cnt - tk3, vecs[r].exp_ticks3);
         chk($sformatf("vec%0d_frame_count_div3", r), frame_count3, vecs[r].exp_fc3);
      end
      chk("vec_end_busy", busy, 0);
      chk("vec_end_overrun", overrun, 0);

      // Seven raw ticks: divide-by-3 instance runs two sequences.
      game_playing = 1'b1;
      do_reset();
      tk  = tick_cnt;
      tk3 = tick3_cnt;
      for (int k = 0; k < 7; k++) begin
         raw_tick(2);
         repeat (26) cyc();
      end
      chk("t2_ticks_div1", tick_cnt - tk, 7);
      chk("t2_frame_count_div1", frame_count, 7);
      chk("t2_ticks_div3", tick3_cnt - tk3, 2);
      chk("t2_frame_count_div3", frame_count3, 2);
      chk("t2_overrun", overrun, 0);

      // Stages 2 and 3 never answer: both time out, first one is recorded.
      dly[2] = 0;
      dly[3] = 0;
      chk("t3_pre_timeout", timeout_err, 0);
      start_seq("t3");
      wait_go(4'b0100, 20, w);
      wait_go(4'b1000, 40, w);
      chk("t3_timeout_gap", w, 17);
      chk("t3_timeout_err", timeout_err, 1);
      chk("t3_err_stage", err_stage, 2);
      wait_idle(40);
      chk("t3_err_stage_first", err_stage, 2);
      chk("t3_frame_count", frame_count, 8);
      dly[2] = 3;
      dly[3] = 3;

      // Stage 1 stalls across the next frame tick.
      dly[1] = 10;
      g0 = go0_cnt;
      start_seq("t4");
      wait_go(4'b0010, 10, w);
      repeat (2) cyc();
      raw_tick(2);
      wait_idle(40);
      repeat (6) cyc();
      chk("t4_overrun", overrun, 1);
      chk("t4_single_sequence", go0_cnt - g0, 1);
      chk("t4_frame_count", frame_count, 9);
      clr_err = 1'b1;
      cyc();
      clr_err = 1'b0;
      chk("t4_clr_overrun", overrun, 0);
      chk("t4_clr_timeout", timeout_err, 0);
      chk("t4_clr_err_stage", err_stage, 0);
      dly[1] = 3;

      // game_playing drops while stage 0 is outstanding.
      g0 = go_pulses;
      start_seq("t5");
      game_playing = 1'b0;
      repeat (8) cyc();
      chk("t5_no_more_go", go_pulses - g0, 1);
      chk("t5_idle", busy, 0);
      chk("t5_frame_count", frame_count, 9);
      game_playing = 1'b1;
      repeat (2) cyc();

      // Asynchronous reset during the wait on stage 1.
      dly[1] = 0;
      start_seq("t6");
      wait_go(4'b0010, 10, w);
      repeat (2) cyc();
      chk("t6_busy_before", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_rst_stage_go", stage_go, 0);
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_frame_count", frame_count, 0);
      chk("t6_rst_flags", {overrun, timeout_err, err_stage, frame_tick}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      dly[1] = 3;
      cyc();
      start_seq("t6_restart");
      wait_idle(40);
      chk("t6_frame_count", frame_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
